// File: rtl/oled_pkg.sv
// Shared geometry, control codes and FSM state types for the OLED text console.
package oled_pkg;

  localparam int NC = 96 / 8;
  localparam int NR = 64 / 8;
  localparam int NB = NC * NR * 8;

  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_BS     = 8'h08;
  localparam logic [7:0] ASCII_CURSOR = 8'h5F;

  typedef enum logic [1:0] {EDIT, SCROLL, CLEAR} edit_state_t;
  typedef enum logic [1:0] {IDLE, START, BUSY} refresh_state_t;

endpackage

// File: rtl/oled_refresh_ctrl.sv
// Refresh handshake with OLED_interface: snapshots the frame when dirty and
// raises start until the driver acknowledges by dropping its ready.
module oled_refresh_ctrl
  import oled_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic dirty,
  input  logic oled_ready,
  input  logic edit_idle,
  output logic start,
  output logic snapshot
);

  refresh_state_t state;

  assign snapshot = (state == IDLE) && dirty && oled_ready && edit_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      start <= 1'b0;
    end else begin
      case (state)
        IDLE: if (snapshot) begin
          state <= START;
          start <= 1'b1;
        end
        START: if (!oled_ready) begin
          state <= BUSY;
          start <= 1'b0;
        end
        BUSY: if (oled_ready) state <= IDLE;
        default: begin
          state <= IDLE;
          start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/oled_text_console.sv
// Writable character console feeding OLED_interface text mode.
// Optional cursor blink overlay: define OLED_CONSOLE_CURSOR_BLINK_EN.
module oled_text_console #(
  parameter int         NUM_COL        = 96,
  parameter int         NUM_ROW        = 64,
  parameter int         ASCII_COL_SIZE = 8,
  parameter int         ASCII_ROW_SIZE = 8,
  parameter logic [7:0] FILL_CHAR      = 8'h20,
  parameter int         BLINK_PERIOD   = 25000000,
  localparam int NC = NUM_COL / ASCII_COL_SIZE,
  localparam int NR = NUM_ROW / ASCII_ROW_SIZE,
  localparam int NB = NC * NR * 8,
  localparam int CW = (NC > 1) ? $clog2(NC) : 1,
  localparam int RW = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  input  logic [7:0]    i_CHAR,
  input  logic          i_CHAR_VALID,
  output logic          o_CHAR_READY,
  input  logic          i_CLEAR,
  input  logic          i_OLED_READY,
  output logic          o_START,
  output logic [NB-1:0] o_ASCII,
  output logic [CW-1:0] o_CUR_COL,
  output logic [RW-1:0] o_CUR_ROW
);

  import oled_pkg::*;

  localparam logic [CW-1:0]     COL_LAST  = CW'(NC - 1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(NR - 1);
  localparam logic [NC*8-1:0]   BLANK_ROW = {NC{FILL_CHAR}};

  if (NC < 2 || NR < 2 || BLINK_PERIOD < 1) begin : g_param_check
    $error("oled_text_console: unsupported geometry or blink period");
  end

  edit_state_t     edit_state, edit_next;
  logic [RW-1:0]   k;
  logic [CW-1:0]   cur_col;
  logic [RW-1:0]   cur_row;
  logic [NC*8-1:0] rows [NR];
  logic            dirty, char_ready, snapshot, set_dirty;
  logic            take, printable, advance, completion;
  logic [NB-1:0]   frame, snap_frame;

  assign o_CHAR_READY = char_ready;
  assign o_CUR_COL    = cur_col;
  assign o_CUR_ROW    = cur_row;

  assign take       = i_CHAR_VALID && char_ready && !i_CLEAR;
  assign printable  = (i_CHAR >= 8'h20) && (i_CHAR <= 8'h7E);
  assign advance    = (printable && cur_col == COL_LAST) || (i_CHAR == ASCII_LF);
  assign completion = (edit_state != EDIT) && (k == ROW_LAST) && !i_CLEAR;

`ifdef OLED_CONSOLE_CURSOR_BLINK_EN
  logic [31:0] blink_cnt;
  logic        blink_phase, blink_tick;

  assign blink_tick = (blink_cnt == 32'(BLINK_PERIOD - 1));

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_tick) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

  assign set_dirty = (take && (printable || (i_CHAR == ASCII_BS && cur_col != '0)))
                     || completion || blink_tick;
`else
  assign set_dirty = (take && (printable || (i_CHAR == ASCII_BS && cur_col != '0)))
                     || completion;
`endif

  // Row 0 lands in the most significant bytes so the frame reads like a string literal.
  always_comb begin
    frame = '0;
    for (int r = 0; r < NR; r++) frame[(NR-1-r)*NC*8 +: NC*8] = rows[r];
    snap_frame = frame;
`ifdef OLED_CONSOLE_CURSOR_BLINK_EN
    if (blink_phase)
      snap_frame[((NR-1-int'(cur_row))*NC + (NC-1-int'(cur_col)))*8 +: 8] = ASCII_CURSOR;
`endif
  end

  always_comb begin
    edit_next = edit_state;
    if (i_CLEAR) edit_next = CLEAR;
    else begin
      case (edit_state)
        EDIT:          if (take && advance && cur_row == ROW_LAST) edit_next = SCROLL;
        SCROLL, CLEAR: if (k == ROW_LAST) edit_next = EDIT;
        default:       edit_next = EDIT;
      endcase
    end
  end

  oled_refresh_ctrl u_refresh (
    .clk        (i_CLK),
    .rst        (i_RST),
    .dirty      (dirty),
    .oled_ready (i_OLED_READY),
    .edit_idle  (edit_state == EDIT),
    .start      (o_START),
    .snapshot   (snapshot)
  );

  // A write landing with a snapshot keeps dirty set, so the new content refreshes next.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      for (int r = 0; r < NR; r++) rows[r] <= BLANK_ROW;
      o_ASCII    <= {(NC*NR){FILL_CHAR}};
      edit_state <= EDIT;
      k          <= '0;
      cur_col    <= '0;
      cur_row    <= '0;
      dirty      <= 1'b1;
      char_ready <= 1'b0;
    end else begin
      edit_state <= edit_next;
      char_ready <= (edit_next == EDIT);
      if (snapshot) o_ASCII <= snap_frame;
      if (set_dirty)     dirty <= 1'b1;
      else if (snapshot) dirty <= 1'b0;

      if (i_CLEAR) begin
        k       <= '0;
        cur_col <= '0;
        cur_row <= '0;
      end else begin
        case (edit_state)
          EDIT: if (take) begin
            if (printable) begin
              rows[cur_row][(NC-1-int'(cur_col))*8 +: 8] <= i_CHAR;
              if (cur_col == COL_LAST) begin
                cur_col <= '0;
                if (cur_row != ROW_LAST) cur_row <= cur_row + 1'b1;
              end else begin
                cur_col <= cur_col + 1'b1;
              end
            end else if (i_CHAR == ASCII_LF) begin
              cur_col <= '0;
              if (cur_row != ROW_LAST) cur_row <= cur_row + 1'b1;
            end else if (i_CHAR == ASCII_CR) begin
              cur_col <= '0;
            end else if (i_CHAR == ASCII_BS && cur_col != '0) begin
              cur_col <= cur_col - 1'b1;
              rows[cur_row][(NC-int'(cur_col))*8 +: 8] <= FILL_CHAR;
            end
          end
          SCROLL: begin
            if (k == ROW_LAST) rows[k] <= BLANK_ROW;
            else               rows[k] <= rows[k + 1'b1];
            k <= (k == ROW_LAST) ? '0 : k + 1'b1;
          end
          CLEAR: begin
            rows[k] <= BLANK_ROW;
            k <= (k == ROW_LAST) ? '0 : k + 1'b1;
          end
          default: k <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oled_text_console.sv
// Self-checking bench for oled_text_console: screen-level reference model plus
// an emulated OLED driver that drops READY 3 cycles after START for 100 cycles.
module tb_oled_text_console;

  localparam int NC = 12;
  localparam int NR = 8;
  localparam int NB = NC * NR * 8;

  logic          clk, rst, valid, clr, oled_ready;
  logic [7:0]    ch;
  logic          o_char_ready, o_start;
  logic [NB-1:0] o_ascii;
  logic [3:0]    o_cur_col;
  logic [2:0]    o_cur_row;

  oled_text_console dut (
    .i_CLK        (clk),
    .i_RST        (rst),
    .i_CHAR       (ch),
    .i_CHAR_VALID (valid),
    .o_CHAR_READY (o_char_ready),
    .i_CLEAR      (clr),
    .i_OLED_READY (oled_ready),
    .o_START      (o_start),
    .o_ASCII      (o_ascii),
    .o_CUR_COL    (o_cur_col),
    .o_CUR_ROW    (o_cur_row)
  );

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int low_cnt = 0;
  bit cnt_en = 0;
  bit prev_start = 0;
  bit mvalid = 0;

  // Reference model: visible screen, cursor, busy window and refresh phase.
  logic [7:0] scr      [NR][NC];
  logic [7:0] shadow_m [NR][NC];
  int  cr, cc, busy_left, rs;
  bit  in_busy, m_ready, m_dirty;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic blankScreen();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) scr[r][c] = 8'h20;
  endtask

  task automatic newLine();
    if (cr < NR - 1) cr++;
    else begin
      for (int r = 0; r < NR - 1; r++) scr[r] = scr[r+1];
      for (int c = 0; c < NC; c++) scr[NR-1][c] = 8'h20;
      in_busy = 1; busy_left = NR;
    end
  endtask

  task automatic modelStep();
    bit snap, setd;
    snap = (rs == 0) && m_dirty && oled_ready && !in_busy;
    if (snap) shadow_m = scr;
    case (rs)
      0: if (snap) rs = 1;
      1: if (!oled_ready) rs = 2;
      default: if (oled_ready) rs = 0;
    endcase
    setd = 0;
    if (clr) begin
      blankScreen(); cr = 0; cc = 0; in_busy = 1; busy_left = NR;
    end else if (in_busy) begin
      busy_left--;
      if (busy_left == 0) begin in_busy = 0; setd = 1; end
    end else if (valid && m_ready) begin
      if (ch >= 8'h20 && ch <= 8'h7E) begin
        scr[cr][cc] = ch; setd = 1;
        if (cc == NC - 1) begin cc = 0; newLine(); end
        else cc++;
      end else if (ch == 8'h0A) begin
        cc = 0; newLine();
      end else if (ch == 8'h0D) begin
        cc = 0;
      end else if (ch == 8'h08 && cc > 0) begin
        cc--; scr[cr][cc] = 8'h20; setd = 1;
      end
    end
    if (snap) m_dirty = 0;
    if (setd) m_dirty = 1;
    m_ready = !in_busy;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      blankScreen(); shadow_m = scr;
      cr = 0; cc = 0; busy_left = 0; rs = 0;
      in_busy = 0; m_ready = 0; m_dirty = 1;
      mvalid = 1;
    end else if (mvalid) begin
      modelStep();
    end
  end

  function automatic logic [NB-1:0] expFrame();
    logic [NB-1:0] v = '0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        v[((NR-1-r)*NC + (NC-1-c))*8 +: 8] = shadow_m[r][c];
    return v;
  endfunction

  function automatic logic [7:0] cellOf(int r, int c);
    return o_ascii[((NR-1-r)*NC + (NC-1-c))*8 +: 8];
  endfunction

  task automatic cmpVal(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkOutput();
    logic [NB-1:0] ef;
    ef = expFrame();
    cmpVal("char_ready", 64'(o_char_ready), 64'(m_ready));
    cmpVal("start", 64'(o_start), 64'(rs == 1));
    cmpVal("cur_col", 64'(o_cur_col), 64'(cc));
    cmpVal("cur_row", 64'(o_cur_row), 64'(cr));
    checks++;
    if (o_ascii !== ef) begin
      errors++;
      $display("[TB] FAIL frame got %h want %h", o_ascii, ef);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) checkOutput();
    if (o_start && !prev_start) starts++;
    prev_start = o_start;
    if (cnt_en && !o_char_ready) low_cnt++;
  end

  // Emulated OLED driver.
  initial begin
    oled_ready = 1;
    forever begin
      @(negedge clk);
      if (o_start && oled_ready) begin
        repeat (3) @(negedge clk);
        oled_ready = 0;
        repeat (100) @(negedge clk);
        oled_ready = 1;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] c);
    int n = 0;
    while (!o_char_ready && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!o_char_ready) begin
      errors++;
      $display("[TB] FAIL ready_timeout got %0d cycles want < 300", n);
    end else begin
      ch = c; valid = 1;
      @(negedge clk);
      valid = 0;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    repeat (4) @(negedge clk);
    while (!(rs == 0 && !m_dirty && m_ready && oled_ready && !o_start) && n < 3000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("[TB] FAIL idle_timeout got %0d cycles want < 3000", n);
    end
  endtask

  task automatic pulseClear();
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  function automatic bit allBlank();
    logic [NB-1:0] b = {(NC*NR){8'h20}};
    return o_ascii === b;
  endfunction

  initial begin
    int s0, n;
    rst = 1; valid = 0; clr = 0; ch = 8'h00;
    repeat (3) @(negedge clk);
    rst = 0;

    // Power-up: exactly one blank refresh.
    waitIdle();
    cmpVal("reset_starts", 64'(starts), 64'd1);
    cmpVal("reset_blank", 64'(allBlank()), 64'd1);

    // "HI" then newline.
    applyStimulus(8'h48); applyStimulus(8'h49); applyStimulus(8'h0A);
    waitIdle();
    cmpVal("hi_cell00", 64'(cellOf(0, 0)), 64'h48);
    cmpVal("hi_cell01", 64'(cellOf(0, 1)), 64'h49);
    cmpVal("hi_col", 64'(o_cur_col), 64'd0);
    cmpVal("hi_row", 64'(o_cur_row), 64'd1);

    // Writes while the driver is busy wait for one more refresh.
    s0 = starts;
    applyStimulus(8'h51);
    n = 0;
    while (oled_ready && n < 300) begin @(negedge clk); n++; end
    cmpVal("busy_reached", 64'(oled_ready), 64'd0);
    applyStimulus(8'h52); applyStimulus(8'h53); applyStimulus(8'h54);
    cmpVal("busy_hold_q", 64'(cellOf(1, 0)), 64'h51);
    cmpVal("busy_hold_blank", 64'(cellOf(1, 1)), 64'h20);
    waitIdle();
    cmpVal("busy_starts", 64'(starts - s0), 64'd2);
    cmpVal("busy_final", 64'(cellOf(1, 3)), 64'h54);

    // Backspace at column 0 and column 3.
    applyStimulus(8'h0D); applyStimulus(8'h08);
    cmpVal("bs0_col", 64'(o_cur_col), 64'd0);
    cmpVal("bs0_row", 64'(o_cur_row), 64'd1);
    applyStimulus(8'h61); applyStimulus(8'h62); applyStimulus(8'h63);
    applyStimulus(8'h08);
    cmpVal("bs3_col", 64'(o_cur_col), 64'd2);
    waitIdle();
    cmpVal("bs3_cell", 64'(cellOf(1, 2)), 64'h20);
    cmpVal("bs3_keep", 64'(cellOf(1, 1)), 64'h62);

    // Fill the whole screen plus one character: a single scroll.
    pulseClear();
    waitIdle();
    low_cnt = 0; cnt_en = 1;
    for (int i = 0; i < NC * NR + 1; i++) applyStimulus(8'(8'h41 + (i % 26)));
    cnt_en = 0;
    waitIdle();
    cmpVal("scroll_low", 64'(low_cnt), 64'(NR));
    cmpVal("scroll_last", 64'(cellOf(NR-1, 0)), 64'h53);
    cmpVal("scroll_fill", 64'(cellOf(NR-1, 1)), 64'h20);
    cmpVal("scroll_top", 64'(cellOf(0, 0)), 64'h4D);
    cmpVal("scroll_r6", 64'(cellOf(NR-2, NC-1)), 64'h52);

    // Clear with a simultaneous character in the middle of a scroll.
    for (int i = 0; i < NC - 1; i++) applyStimulus(8'(8'h61 + i));
    @(negedge clk);
    clr = 1; valid = 1; ch = 8'h5A;
    @(negedge clk);
    clr = 0; valid = 0;
    cmpVal("clr_ready", 64'(o_char_ready), 64'd0);
    waitIdle();
    cmpVal("clr_col", 64'(o_cur_col), 64'd0);
    cmpVal("clr_row", 64'(o_cur_row), 64'd0);
    cmpVal("clr_blank", 64'(allBlank()), 64'd1);

    // Randomised traffic, controls and clears.
    for (int i = 0; i < 2500; i++) begin
      valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0:       ch = 8'h0A;
        1:       ch = 8'h0D;
        2:       ch = 8'h08;
        3:       ch = ($urandom_range(0, 1) != 0) ? 8'h7F : 8'h01;
        default: ch = 8'($urandom_range(32, 126));
      endcase
      clr = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    valid = 0; clr = 0;
    waitIdle();

    // Reset in the middle of a refresh request.
    applyStimulus(8'h78);
    n = 0;
    while (!o_start && n < 300) begin @(negedge clk); n++; end
    cmpVal("mid_start_seen", 64'(o_start), 64'd1);
    rst = 1;
    @(negedge clk);
    cmpVal("mid_start_drop", 64'(o_start), 64'd0);
    rst = 0;
    waitIdle();
    cmpVal("mid_blank", 64'(allBlank()), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    errors++;
    $display("[TB] FAIL watchdog got 60000 cycles want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
